// File: rtl/rv32_exec_core.sv
// Execute datapath of a single-cycle RV32 core.
// Contains a 32-entry register file, a one-hot funct3 decoder and a one-hot ALU / next-PC unit.
module rv32_exec_core #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_wen,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [6:0]      alu_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [7:0]      funct3_hot,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic            mem_ren,
  output logic [XLEN-1:0] mem_raddr,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] next_pc
);

  localparam int OP_AUIPC = 0;
  localparam int OP_LUI   = 1;
  localparam int OP_JAL   = 2;
  localparam int OP_JALR  = 3;
  localparam int OP_ADDI  = 4;
  localparam int OP_ADD   = 5;
  localparam int OP_LW    = 6;

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] src1_plus_imm;

  // Write port: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_wen && (rd != 5'd0)) begin
      regs[rd] <= result;
    end
  end

  // Read ports have no bypass: a same-cycle write is only visible after the edge.
  assign src1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign src2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign funct3_hot = 8'b1 << funct3;

  assign pc_plus4      = pc + XLEN'(4);
  assign pc_plus_imm   = pc + imm;
  assign src1_plus_imm = src1 + imm;

  assign mem_ren   = alu_op[OP_LW];
  assign mem_raddr = alu_op[OP_LW] ? src1_plus_imm : '0;

  // Lowest set alu_op bit wins if decode ever presents more than one.
  always_comb begin
    result  = '0;
    next_pc = pc_plus4;
    if (alu_op[OP_AUIPC]) begin
      result = pc_plus_imm;
    end else if (alu_op[OP_LUI]) begin
      result = imm;
    end else if (alu_op[OP_JAL]) begin
      result  = pc_plus4;
      next_pc = pc_plus_imm;
    end else if (alu_op[OP_JALR]) begin
      result  = pc_plus4;
      next_pc = src1_plus_imm & ~XLEN'(1);
    end else if (alu_op[OP_ADDI]) begin
      result = src1_plus_imm;
    end else if (alu_op[OP_ADD]) begin
      result = src1 + src2;
    end else if (alu_op[OP_LW]) begin
      result = mem_rdata;
    end
  end

endmodule

// File: tb/tb_rv32_exec_core.sv
// Self-checking bench for rv32_exec_core: directed scenarios plus randomized traffic
// compared against an architectural register-file model.
module tb_rv32_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wen;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  alu_op;
  logic [31:0] imm, pc, mem_rdata;
  logic [2:0]  funct3;
  logic [7:0]  funct3_hot;
  logic [31:0] src1, src2, mem_raddr, result, next_pc;
  logic        mem_ren;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mregs [32];

  always #5 clk = ~clk;

  rv32_exec_core dut (
    .clk(clk), .rst(rst), .reg_wen(reg_wen), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .imm(imm), .pc(pc), .funct3(funct3), .mem_rdata(mem_rdata),
    .funct3_hot(funct3_hot), .src1(src1), .src2(src2), .mem_ren(mem_ren),
    .mem_raddr(mem_raddr), .result(result), .next_pc(next_pc)
  );

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mregs[a];
  endfunction

  function automatic int op_index(input logic [6:0] op);
    for (int i = 0; i < 7; i++) if (op[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] a = m_read(rs1);
    logic [31:0] b = m_read(rs2);
    case (op_index(alu_op))
      0: return pc + imm;
      1: return imm;
      2: return pc + 32'd4;
      3: return pc + 32'd4;
      4: return a + imm;
      5: return a + b;
      6: return mem_rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_next_pc();
    case (op_index(alu_op))
      2: return pc + imm;
      3: return {m_read(rs1) + imm} & 32'hFFFF_FFFE;
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic set_in(input logic [6:0] op, input logic wen, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] d, input logic [31:0] im,
                        input logic [31:0] p);
    alu_op = op; reg_wen = wen; rs1 = a1; rs2 = a2; rd = d; imm = im; pc = p;
    #1;
  endtask

  // Clock one edge, committing the model's write-back computed from pre-edge state.
  task automatic tick();
    logic [31:0] wb;
    wb = m_result();
    @(posedge clk);
    if (!rst && reg_wen && rd != 5'd0) mregs[rd] = wb;
    #1;
  endtask

  task automatic test_reset();
    set_in(7'b0000010, 1'b1, 5'd5, 5'd0, 5'd5, 32'h0000_1234, 32'h0);
    tick();
    n_tests++;
    if (src1 !== 32'h1234) begin n_fail++; $display("FAIL reset_pre_write src1=%h exp=%h", src1, 32'h1234); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (src1 !== 32'h0) begin n_fail++; $display("FAIL reset_async src1=%h exp=0", src1); end
    @(posedge clk); #1;
    n_tests++;
    if (src1 !== 32'h0) begin n_fail++; $display("FAIL reset_write_ignored src1=%h exp=0", src1); end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    #1;
  endtask

  task automatic test_x0_funct3();
    set_in(7'b0010000, 1'b1, 5'd0, 5'd0, 5'd0, 32'd7, 32'h0);
    funct3 = 3'b101;
    #1;
    n_tests++;
    if (funct3_hot !== 8'h20) begin n_fail++; $display("FAIL funct3_hot got=%h exp=20", funct3_hot); end
    tick();
    n_tests++;
    if (src1 !== 32'h0) begin n_fail++; $display("FAIL x0_write got=%h exp=0", src1); end
    for (int f = 0; f < 8; f++) begin
      funct3 = 3'(f); #1;
      n_tests++;
      if (funct3_hot !== (8'h1 << f)) begin n_fail++; $display("FAIL funct3_hot_%0d got=%h", f, funct3_hot); end
    end
  endtask

  task automatic test_add_chain();
    set_in(7'b0010000, 1'b1, 5'd0, 5'd1, 5'd1, 32'h10, 32'h100);
    n_tests++;
    if (src2 !== 32'h0) begin n_fail++; $display("FAIL no_bypass src2=%h exp=0", src2); end
    tick();
    set_in(7'b0100000, 1'b1, 5'd1, 5'd1, 5'd2, 32'h0, 32'h104);
    n_tests++;
    if (result !== 32'h20) begin n_fail++; $display("FAIL add_result got=%h exp=20", result); end
    tick();
    set_in(7'b0000000, 1'b0, 5'd2, 5'd1, 5'd0, 32'h0, 32'h108);
    n_tests++;
    if (src1 !== 32'h20 || src2 !== 32'h10) begin
      n_fail++; $display("FAIL add_chain x2=%h x1=%h exp=20/10", src1, src2);
    end
    n_tests++;
    if (result !== 32'h0 || next_pc !== 32'h10C) begin
      n_fail++; $display("FAIL no_op result=%h next_pc=%h exp=0/10c", result, next_pc);
    end
  endtask

  task automatic test_jumps();
    set_in(7'b0000100, 1'b0, 5'd0, 5'd0, 5'd0, 32'h8, 32'h8000_0000);
    n_tests++;
    if (result !== 32'h8000_0004 || next_pc !== 32'h8000_0008) begin
      n_fail++; $display("FAIL jal result=%h next_pc=%h exp=80000004/80000008", result, next_pc);
    end
    set_in(7'b0000010, 1'b1, 5'd0, 5'd0, 5'd3, 32'h8000_0101, 32'h0);
    tick();
    set_in(7'b0001000, 1'b1, 5'd3, 5'd0, 5'd3, 32'h0, 32'h4000_0000);
    n_tests++;
    if (next_pc !== 32'h8000_0100 || result !== 32'h4000_0004) begin
      n_fail++; $display("FAIL jalr next_pc=%h result=%h exp=80000100/40000004", next_pc, result);
    end
    tick();
    n_tests++;
    if (src1 !== 32'h4000_0004) begin n_fail++; $display("FAIL jalr_link got=%h exp=40000004", src1); end
  endtask

  task automatic test_lui_auipc();
    set_in(7'b0000010, 1'b0, 5'd0, 5'd0, 5'd0, 32'hABCD_E000, 32'h1234);
    n_tests++;
    if (result !== 32'hABCD_E000) begin n_fail++; $display("FAIL lui got=%h exp=abcde000", result); end
    set_in(7'b0000001, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1000, 32'h8000_0000);
    n_tests++;
    if (result !== 32'h8000_1000 || next_pc !== 32'h8000_0004) begin
      n_fail++; $display("FAIL auipc result=%h next_pc=%h exp=80001000/80000004", result, next_pc);
    end
    set_in(7'b0100000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFC);
    n_tests++;
    if (next_pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got=%h exp=0", next_pc); end
    set_in(7'b0010110, 1'b0, 5'd0, 5'd0, 5'd0, 32'h40, 32'h200);
    n_tests++;
    if (result !== 32'h40 || next_pc !== 32'h204) begin
      n_fail++; $display("FAIL priority result=%h next_pc=%h exp=40/204", result, next_pc);
    end
  endtask

  task automatic test_lw();
    set_in(7'b0000010, 1'b1, 5'd0, 5'd0, 5'd4, 32'h8000_0010, 32'h0);
    tick();
    mem_rdata = 32'hDEAD_BEEF;
    set_in(7'b1000000, 1'b1, 5'd4, 5'd0, 5'd6, 32'hFFFF_FFFC, 32'h0);
    n_tests++;
    if (mem_ren !== 1'b1 || mem_raddr !== 32'h8000_000C) begin
      n_fail++; $display("FAIL lw_addr ren=%b addr=%h exp=1/8000000c", mem_ren, mem_raddr);
    end
    tick();
    set_in(7'b0000000, 1'b0, 5'd6, 5'd4, 5'd0, 32'h5, 32'h0);
    n_tests++;
    if (src1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_wb got=%h exp=deadbeef", src1); end
    n_tests++;
    if (mem_ren !== 1'b0 || mem_raddr !== 32'h0) begin
      n_fail++; $display("FAIL lw_idle ren=%b addr=%h exp=0/0", mem_ren, mem_raddr);
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int k = 0; k < 400; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ((k % 8 == 7) ? 7'h0 : 7'(1 << $urandom_range(0, 6)));
      mem_rdata = $urandom;
      funct3    = 3'($urandom);
      set_in(op, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom);
      n_tests++;
      if (src1 !== m_read(rs1) || src2 !== m_read(rs2)) begin
        n_fail++; $display("FAIL rnd_read k=%0d src1=%h src2=%h exp=%h/%h", k, src1, src2, m_read(rs1), m_read(rs2));
      end
      n_tests++;
      if (result !== m_result() || next_pc !== m_next_pc()) begin
        n_fail++; $display("FAIL rnd_alu k=%0d op=%b result=%h next_pc=%h exp=%h/%h", k, op, result, next_pc, m_result(), m_next_pc());
      end
      n_tests++;
      if (mem_ren !== op[6] || mem_raddr !== (op[6] ? m_read(rs1) + imm : 32'h0) || funct3_hot !== (8'h1 << funct3)) begin
        n_fail++; $display("FAIL rnd_mem k=%0d ren=%b addr=%h hot=%h", k, mem_ren, mem_raddr, funct3_hot);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; reg_wen = 1'b0; rs1 = '0; rs2 = '0; rd = '0; alu_op = '0;
    imm = '0; pc = '0; funct3 = '0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_in(7'h0, 1'b0, 5'd7, 5'd31, 5'd0, 32'h0, 32'h0);
    n_tests++;
    if (src1 !== 32'h0 || src2 !== 32'h0) begin n_fail++; $display("FAIL reset_state src1=%h src2=%h exp=0", src1, src2); end
    test_reset();
    test_x0_funct3();
    test_add_chain();
    test_jumps();
    test_lui_auipc();
    test_lw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
